// File: rtl/fp_sub_pkg.sv
// Shared types and constants for the sequential half-precision-style subtractor.
package fp_sub_pkg;

  localparam int DEF_E_WIDTH = 5;
  localparam int DEF_M_WIDTH = 10;
  localparam int DEF_BIAS    = (1 << (DEF_E_WIDTH - 1)) - 1;

  // Guard, round and sticky bits carried below the stored mantissa
  localparam int GRS_BITS    = 3;

  // Extended mantissa: hidden bit + stored mantissa + guard/round/sticky
  localparam int DEF_X_WIDTH = DEF_M_WIDTH + 1 + GRS_BITS;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_SUB   = 3'd2,
    ST_NORM  = 3'd3,
    ST_ROUND = 3'd4,
    ST_DONE  = 3'd5
  } fsm_state_t;

  // Extended-mantissa width for an arbitrary stored mantissa width
  function automatic int ext_mant_width(input int m_width);
    return m_width + 1 + GRS_BITS;
  endfunction

endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even on an extended mantissa {hidden, mant, G, R, S}.
// A carry out of the rounding add renormalises by one and bumps the exponent;
// ovf reports an exponent beyond the largest encodable one.
module fp_rne_round
  import fp_sub_pkg::*;
#(
  parameter int X_W     = DEF_X_WIDTH,
  parameter int EXP_W   = DEF_E_WIDTH + 2,
  parameter int EXP_MAX = (1 << DEF_E_WIDTH) - 1 - DEF_BIAS
) (
  input  logic [X_W-1:0]          man_in,
  input  logic signed [EXP_W-1:0] exp_in,
  output logic [X_W-GRS_BITS-2:0] mant_out,
  output logic signed [EXP_W-1:0] exp_out,
  output logic                    ovf
);

  localparam int M_W = X_W - 1 - GRS_BITS;
  localparam logic signed [EXP_W-1:0] EXP_MAX_S = EXP_W'(EXP_MAX);

  logic           inc;
  logic [M_W+1:0] sum;
  logic           carry;

  // Increment on G and (R or S or LSB); renormalise if the add carries out
  always_comb begin
    inc      = man_in[2] & (man_in[1] | man_in[0] | man_in[GRS_BITS]);
    sum      = {1'b0, man_in[X_W-1:GRS_BITS]} + {{(M_W + 1){1'b0}}, inc};
    carry    = sum[M_W+1];
    mant_out = carry ? sum[M_W:1] : sum[M_W-1:0];
    exp_out  = carry ? exp_in + EXP_W'(1) : exp_in;
    ovf      = (exp_out > EXP_MAX_S);
  end

endmodule

// File: rtl/fp_subtraction_seq.sv
// Multi-cycle floating-point subtractor p = a - b with valid/ready handshakes.
// Alignment and normalisation shift one bit per cycle, so latency depends on
// the exponent difference and the cancellation depth. Exponents are kept
// unbiased internally so the range limits read as true exponent bounds.
module fp_subtraction_seq
  import fp_sub_pkg::*;
#(
  parameter int E_WIDTH = DEF_E_WIDTH,
  parameter int M_WIDTH = DEF_M_WIDTH,
  parameter int BIAS    = (1 << (E_WIDTH - 1)) - 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [E_WIDTH+M_WIDTH:0] a,
  input  logic [E_WIDTH+M_WIDTH:0] b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [E_WIDTH+M_WIDTH:0] p,
  output logic                     flag_zero,
  output logic                     flag_ovf,
  output logic                     flag_unf
);

  localparam int W       = 1 + E_WIDTH + M_WIDTH;
  localparam int X_W     = ext_mant_width(M_WIDTH);
  localparam int EXP_W   = E_WIDTH + 2;
  localparam int K_MAX   = M_WIDTH + 3;
  localparam int CNT_W   = $clog2(K_MAX + 1);
  localparam int EXP_MAX = (1 << E_WIDTH) - 1 - BIAS;
  localparam logic signed [EXP_W-1:0] EXP_MIN_S = EXP_W'(1 - BIAS);

  fsm_state_t state_q, state_d;

  logic                    sign_q;
  logic                    eff_sub_q;
  logic signed [EXP_W-1:0] exp_q;
  logic [X_W-1:0]          man_big_q;
  logic [X_W-1:0]          man_small_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    zero_q;
  logic                    unf_q;

  logic [E_WIDTH-1:0]         exp_a, exp_b, exp_big, exp_diff;
  logic                       a_zero, b_zero, a_big;
  logic [E_WIDTH+M_WIDTH-1:0] key_a, key_b;
  logic [X_W-1:0]             man_a, man_b;
  logic [CNT_W-1:0]           k_start;
  logic                       eff_sub_in, sign_in;
  logic signed [EXP_W-1:0]    exp_big_unb;

  logic [X_W:0]            sum_add;
  logic [X_W-1:0]          sub_man, norm_man;
  logic signed [EXP_W-1:0] sub_exp, norm_exp;
  logic                    sub_zero, sub_norm, sub_unf;
  logic                    norm_more, norm_unf;

  logic [M_WIDTH-1:0]      rnd_mant;
  logic signed [EXP_W-1:0] rnd_exp;
  logic                    rnd_ovf;
  logic [E_WIDTH-1:0]      exp_field;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);

  // Operand decode: flush exp==0 to zero, pick the larger magnitude, derive shift count
  always_comb begin
    exp_a       = a[W-2:M_WIDTH];
    exp_b       = b[W-2:M_WIDTH];
    a_zero      = (exp_a == '0);
    b_zero      = (exp_b == '0);
    key_a       = a_zero ? '0 : a[W-2:0];
    key_b       = b_zero ? '0 : b[W-2:0];
    man_a       = a_zero ? '0 : {1'b1, a[M_WIDTH-1:0], {GRS_BITS{1'b0}}};
    man_b       = b_zero ? '0 : {1'b1, b[M_WIDTH-1:0], {GRS_BITS{1'b0}}};
    a_big       = (key_a >= key_b);
    exp_big     = a_big ? exp_a : exp_b;
    exp_diff    = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
    k_start     = (int'(exp_diff) > K_MAX) ? CNT_W'(K_MAX) : CNT_W'(exp_diff);
    eff_sub_in  = (a[W-1] == b[W-1]);
    sign_in     = a_big ? a[W-1] : ~b[W-1];
    exp_big_unb = EXP_W'(exp_big) - EXP_W'(BIAS);
  end

  // Add/subtract result and single-step normalisation candidates
  always_comb begin
    sum_add = {1'b0, man_big_q} + {1'b0, man_small_q};
    sub_man = sum_add[X_W-1:0];
    sub_exp = exp_q;
    if (eff_sub_q) begin
      sub_man = man_big_q - man_small_q;
    end else if (sum_add[X_W]) begin
      sub_man = {sum_add[X_W:2], sum_add[1] | sum_add[0]};
      sub_exp = exp_q + EXP_W'(1);
    end
    sub_zero  = (sub_man == '0);
    sub_norm  = !sub_man[X_W-1] && !sub_zero;
    sub_unf   = sub_norm && (sub_exp == EXP_MIN_S);
    norm_man  = {man_big_q[X_W-2:0], 1'b0};
    norm_exp  = exp_q - EXP_W'(1);
    norm_more = !norm_man[X_W-1];
    norm_unf  = norm_more && (norm_exp == EXP_MIN_S);
  end

  fp_rne_round #(
    .X_W     (X_W),
    .EXP_W   (EXP_W),
    .EXP_MAX (EXP_MAX)
  ) u_round (
    .man_in   (man_big_q),
    .exp_in   (exp_q),
    .mant_out (rnd_mant),
    .exp_out  (rnd_exp),
    .ovf      (rnd_ovf)
  );

  assign exp_field = E_WIDTH'(rnd_exp + EXP_W'(BIAS));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a would-be underflow skips straight to ROUND
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (in_valid) state_d = (k_start == '0) ? ST_SUB : ST_ALIGN;
      ST_ALIGN: if (cnt_q == CNT_W'(1)) state_d = ST_SUB;
      ST_SUB:   state_d = (sub_norm && !sub_unf) ? ST_NORM : ST_ROUND;
      ST_NORM:  state_d = (norm_more && !norm_unf) ? ST_NORM : ST_ROUND;
      ST_ROUND: state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath registers: load, align with sticky, add/sub, normalise, round
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q      <= 1'b0;
      eff_sub_q   <= 1'b0;
      exp_q       <= '0;
      man_big_q   <= '0;
      man_small_q <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      unf_q       <= 1'b0;
      p           <= '0;
      flag_zero   <= 1'b0;
      flag_ovf    <= 1'b0;
      flag_unf    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            sign_q      <= sign_in;
            eff_sub_q   <= eff_sub_in;
            exp_q       <= exp_big_unb;
            man_big_q   <= a_big ? man_a : man_b;
            man_small_q <= a_big ? man_b : man_a;
            cnt_q       <= k_start;
            zero_q      <= 1'b0;
            unf_q       <= 1'b0;
          end
        end
        ST_ALIGN: begin
          man_small_q <= {1'b0, man_small_q[X_W-1:2], man_small_q[1] | man_small_q[0]};
          cnt_q       <= cnt_q - CNT_W'(1);
        end
        ST_SUB: begin
          man_big_q <= sub_man;
          exp_q     <= sub_exp;
          zero_q    <= sub_zero;
          unf_q     <= sub_unf;
        end
        ST_NORM: begin
          man_big_q <= norm_man;
          exp_q     <= norm_exp;
          unf_q     <= norm_unf;
        end
        ST_ROUND: begin
          flag_zero <= 1'b0;
          flag_ovf  <= 1'b0;
          flag_unf  <= 1'b0;
          if (zero_q) begin
            p         <= '0;
            flag_zero <= 1'b1;
          end else if (unf_q) begin
            p         <= '0;
            flag_zero <= 1'b1;
            flag_unf  <= 1'b1;
          end else if (rnd_ovf) begin
            p        <= {sign_q, {E_WIDTH{1'b1}}, {M_WIDTH{1'b1}}};
            flag_ovf <= 1'b1;
          end else begin
            p <= {sign_q, exp_field, rnd_mant};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_subtraction_seq.sv
// Directed bench for fp_subtraction_seq (E_WIDTH=5, M_WIDTH=10).
module tb_fp_subtraction_seq;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a         = '0;
  logic [15:0] b         = '0;
  logic        in_ready, out_valid, flag_zero, flag_ovf, flag_unf;
  logic [15:0] p;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [15:0] av;
    logic [15:0] bv;
    logic [15:0] pv;
    logic [2:0]  fv;
    logic [7:0]  lat;
  } vec_t;

  always #5 clk = ~clk;

  fp_subtraction_seq #(.E_WIDTH(5), .M_WIDTH(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .flag_zero (flag_zero),
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf)
  );

  // Drive one operand pair, wait for the result and complete the handshake
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv,
                       output logic [15:0] pv, output logic [2:0] fv,
                       output int lat, output logic rdy_busy);
    @(negedge clk);
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    pv = p;
    fv = {flag_zero, flag_ovf, flag_unf};
    rdy_busy = in_ready;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (p !== 16'h0000) $display("[TB] FAIL reset p: got %h expected 0000", p); else n_pass++;
    n_checks++; if ({flag_zero, flag_ovf, flag_unf} !== 3'b000) $display("[TB] FAIL reset flags: got %b expected 000", {flag_zero, flag_ovf, flag_unf}); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset out_valid: got %b expected 0", out_valid); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset in_ready: got %b expected 1", in_ready); else n_pass++;
  endtask

  task automatic test_subtract();
    vec_t v[3];
    logic [15:0] pv; logic [2:0] fv; int lat; logic rdy;
    v[0] = '{16'h3E00, 16'h3C00, 16'h3800, 3'b000, 8'd3};
    v[1] = '{16'h3C00, 16'h4000, 16'hBC00, 3'b000, 8'd4};
    v[2] = '{16'h0000, 16'h3C00, 16'hBC00, 3'b000, 8'd15};
    for (int i = 0; i < 3; i++) begin
      do_op(v[i].av, v[i].bv, pv, fv, lat, rdy);
      n_checks++; if (pv !== v[i].pv) $display("[TB] FAIL subtract[%0d] p: got %h expected %h", i, pv, v[i].pv); else n_pass++;
      n_checks++; if (fv !== v[i].fv) $display("[TB] FAIL subtract[%0d] flags: got %b expected %b", i, fv, v[i].fv); else n_pass++;
      n_checks++; if (lat !== int'(v[i].lat)) $display("[TB] FAIL subtract[%0d] latency: got %0d expected %0d", i, lat, v[i].lat); else n_pass++;
    end
  endtask

  task automatic test_zero();
    vec_t v[3];
    logic [15:0] pv; logic [2:0] fv; int lat; logic rdy;
    v[0] = '{16'h3C00, 16'h3C00, 16'h0000, 3'b100, 8'd2};
    v[1] = '{16'h8000, 16'h0000, 16'h0000, 3'b100, 8'd2};
    v[2] = '{16'h0401, 16'h0400, 16'h0000, 3'b101, 8'd2};
    for (int i = 0; i < 3; i++) begin
      do_op(v[i].av, v[i].bv, pv, fv, lat, rdy);
      n_checks++; if (pv !== v[i].pv) $display("[TB] FAIL zero[%0d] p: got %h expected %h", i, pv, v[i].pv); else n_pass++;
      n_checks++; if (fv !== v[i].fv) $display("[TB] FAIL zero[%0d] flags: got %b expected %b", i, fv, v[i].fv); else n_pass++;
      n_checks++; if (lat !== int'(v[i].lat)) $display("[TB] FAIL zero[%0d] latency: got %0d expected %0d", i, lat, v[i].lat); else n_pass++;
    end
  endtask

  task automatic test_carry_saturate();
    vec_t v[3];
    logic [15:0] pv; logic [2:0] fv; int lat; logic rdy;
    v[0] = '{16'h3C00, 16'hBC00, 16'h4000, 3'b000, 8'd2};
    v[1] = '{16'h7FFF, 16'hFFFF, 16'h7FFF, 3'b010, 8'd2};
    v[2] = '{16'hFFFF, 16'h7FFF, 16'hFFFF, 3'b010, 8'd2};
    for (int i = 0; i < 3; i++) begin
      do_op(v[i].av, v[i].bv, pv, fv, lat, rdy);
      n_checks++; if (pv !== v[i].pv) $display("[TB] FAIL carry[%0d] p: got %h expected %h", i, pv, v[i].pv); else n_pass++;
      n_checks++; if (fv !== v[i].fv) $display("[TB] FAIL carry[%0d] flags: got %b expected %b", i, fv, v[i].fv); else n_pass++;
      n_checks++; if (lat !== int'(v[i].lat)) $display("[TB] FAIL carry[%0d] latency: got %0d expected %0d", i, lat, v[i].lat); else n_pass++;
    end
  endtask

  task automatic test_align_round();
    vec_t v[4];
    logic [15:0] pv; logic [2:0] fv; int lat; logic rdy;
    v[0] = '{16'h3C00, 16'h2C00, 16'h3B80, 3'b000, 8'd7};
    v[1] = '{16'h7800, 16'h0400, 16'h7800, 3'b000, 8'd16};
    v[2] = '{16'h3C00, 16'h9000, 16'h3C00, 3'b000, 8'd13};
    v[3] = '{16'h3C01, 16'h9000, 16'h3C02, 3'b000, 8'd13};
    for (int i = 0; i < 4; i++) begin
      do_op(v[i].av, v[i].bv, pv, fv, lat, rdy);
      n_checks++; if (pv !== v[i].pv) $display("[TB] FAIL align[%0d] p: got %h expected %h", i, pv, v[i].pv); else n_pass++;
      n_checks++; if (fv !== v[i].fv) $display("[TB] FAIL align[%0d] flags: got %b expected %b", i, fv, v[i].fv); else n_pass++;
      n_checks++; if (lat !== int'(v[i].lat)) $display("[TB] FAIL align[%0d] latency: got %0d expected %0d", i, lat, v[i].lat); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pv; logic [2:0] fv; int lat; logic rdy;
    do_op(16'h3C00, 16'hBC00, pv, fv, lat, rdy);
    n_checks++; if (rdy !== 1'b0) $display("[TB] FAIL b2b in_ready in DONE: got %b expected 0", rdy); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("[TB] FAIL b2b in_ready after handshake: got %b expected 1", in_ready); else n_pass++;
    do_op(16'h3E00, 16'h3C00, pv, fv, lat, rdy);
    n_checks++; if (pv !== 16'h3800) $display("[TB] FAIL b2b second p: got %h expected 3800", pv); else n_pass++;
    n_checks++; if (lat !== 3) $display("[TB] FAIL b2b second latency: got %0d expected 3", lat); else n_pass++;
  endtask

  task automatic test_hold_and_reset();
    int lat, seen;
    logic [15:0] pv; logic [2:0] fv; logic rdy;
    @(negedge clk);
    a = 16'h3E00; b = 16'h3C00; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++; if (lat !== 3) $display("[TB] FAIL hold latency: got %0d expected 3", lat); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 16'h4000; b = 16'h3C00; in_valid = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (p !== 16'h3800 || out_valid !== 1'b1) $display("[TB] FAIL hold[%0d] p/out_valid: got %h/%b expected 3800/1", i, p, out_valid); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("[TB] FAIL hold[%0d] in_ready: got %b expected 0", i, in_ready); else n_pass++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("[TB] FAIL hold release in_ready/out_valid: got %b/%b expected 1/0", in_ready, out_valid); else n_pass++;
    n_checks++; if (p !== 16'h3800) $display("[TB] FAIL hold release p: got %h expected 3800", p); else n_pass++;

    @(negedge clk);
    a = 16'h3C00; b = 16'h2C00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || p !== 16'h0000) $display("[TB] FAIL midreset out_valid/p: got %b/%h expected 0/0000", out_valid, p); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) $display("[TB] FAIL midreset in_ready: got %b expected 1", in_ready); else n_pass++;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_checks++; if (seen !== 0) $display("[TB] FAIL midreset stray out_valid cycles: got %0d expected 0", seen); else n_pass++;
    do_op(16'h3E00, 16'h3C00, pv, fv, lat, rdy);
    n_checks++; if (pv !== 16'h3800 || lat !== 3) $display("[TB] FAIL midreset recovery p/latency: got %h/%0d expected 3800/3", pv, lat); else n_pass++;
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_subtract();
    test_zero();
    test_carry_saturate();
    test_align_round();
    test_back_to_back();
    test_hold_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fp_subtraction_seq.md
FP_SUBTRACTION_SEQ -- requirements
Module: fp_subtraction_seq

Interface
REQ-001 SHALL have parameter E_WIDTH, default 5, exponent field width.
REQ-002 SHALL have parameter M_WIDTH, default 10, stored mantissa width; the leading 1 is hidden.
REQ-003 SHALL have parameter BIAS, default 2^(E_WIDTH-1)-1, exponent bias.
REQ-004 SHALL use one clock and an asynchronous, active-low reset:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have the following data and handshake ports (W = 1+E_WIDTH+M_WIDTH):
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands.
- a  in  W  minuend, format {sign, exp, mant}.
- b  in  W  subtrahend, same format.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- p  out  W  result a-b, same format.
- flag_zero  out  1  result is +0.
- flag_ovf  out  1  result saturated.
- flag_unf  out  1  result flushed to zero.

Function
REQ-006 SHALL compute p = a - b: effective addition when signs differ, otherwise magnitude subtraction; the result sign is that of the larger-magnitude operand after the sign flip of b.
REQ-007 SHALL treat exp==0 as zero (flush-to-zero); SHALL have no infinities or NaNs; SHALL treat exp all-ones as an ordinary value.
REQ-008 SHALL accept operands on a clock edge where in_valid && in_ready; in_ready SHALL be high only in IDLE.
REQ-009 SHALL implement an FSM with the states and transitions below:
- IDLE: to ALIGN on accept, or directly to SUB when k==0.
- ALIGN: k cycles.
- SUB: 1 cycle.
- NORM: n cycles.
- ROUND: 1 cycle.
- DONE: to IDLE on out_valid && out_ready.
REQ-010 SHALL define d = |exp_a - exp_b| and k = min(d, M_WIDTH+3).
- ALIGN SHALL right-shift the smaller operand's extended mantissa by 1 bit per cycle.
- The extended mantissa is hidden bit + M_WIDTH + guard + round + sticky.
- Bits shifted out SHALL be ORed into sticky.
- When d > M_WIDTH+3, after k shifts the mantissa SHALL be fully collapsed into sticky.
REQ-011 SHALL, in SUB, perform the add or subtract. On a carry-out it SHALL right-shift by 1 (sticky preserved) and increment the exponent in the same cycle.
REQ-012 SHALL, in NORM, left-shift 1 bit per cycle and decrement the exponent while the hidden bit is 0 and the mantissa is non-zero; n is the number of such shifts.
REQ-013 SHALL set flag_unf and output +0 when the exponent would fall below 1.
REQ-014 SHALL, in ROUND, round to nearest-even using guard/round/sticky. A mantissa overflow from rounding SHALL increment the exponent.
REQ-015 SHALL saturate the result to max magnitude (exp all-ones, mant all-ones, sign kept) and set flag_ovf when the exponent exceeds all-ones.
REQ-016 SHALL output +0 with flag_zero=1 and n=0 when the SUB result is zero, including a==b and both operands zero.
REQ-017 SHALL assert out_valid exactly k+n+2 cycles after the accepting edge.
REQ-018 SHALL hold p and the flags stable while out_valid && !out_ready.
REQ-019 SHALL raise in_ready the cycle after the DONE handshake; there is no same-cycle bypass.
REQ-020 SHALL ignore in_valid when not in IDLE.

Reset
REQ-021 SHALL, while rst_n is low, force:
- state IDLE;
- p = 0 and all flags 0;
- out_valid = 0;
- all internal registers 0.
REQ-022 SHALL drive in_ready = 1 in the first cycle after deassertion.
REQ-023 SHALL discard any in-flight operation when reset asserts mid-operation; no result is produced.

Structure
REQ-024 SHALL place the FSM state enum, the default widths and bias, and the extended-mantissa width constant in package fp_sub_pkg.
REQ-025 SHALL place the RNE logic in combinational sub-module fp_rne_round (mantissa+GRS, exponent in; rounded mantissa, exponent, overflow out).

Verification
REQ-026 SHALL cover these directed scenarios (E_WIDTH=5, M_WIDTH=10):
- a=0x3E00 (1.5), b=0x3C00 (1.0) -> p=0x3800 (0.5), n=1, out_valid at 3 cycles.
- a=0x3C00, b=0x3C00 -> p=0x0000, flag_zero=1, at 2 cycles.
- a=0x3C00, b=0xBC00 (-1.0) -> p=0x4000 (2.0), carry path, at 2 cycles.
- a=0x7FFF, b=0xFFFF -> p=0x7FFF, flag_ovf=1.
- a=0x3C00, b=0x2C00 (2^-4) -> p=0x3B80 (0.9375), k=4, n=1, at 7 cycles.
- Hold out_ready low for 5 cycles after out_valid -> p stable, in_ready=0; then reset mid-ALIGN -> out_valid stays 0, in_ready=1 after release.
